rx_unpack_64_to_32: RTL and testbench
=====================================

Name: rx_unpack_64_to_32

Overview:
- Stage directly downstream of the MRAM RX RDATA FIFO in the external-peripheral uDMA path.
- Pops 64-bit read beats and emits them as a 32-bit word stream into the uDMA RX channel, low half first.
- Tracks a per-transfer byte count. Trims the unused half of the first and last beat. Signals end of transfer.
- Decouples the MRAM 64-bit datapath from the 32-bit uDMA channel width.

Parameters:
- TRANS_SIZE, 16, width of the transfer byte-size field; matches the uDMA channel size register.

Ports:
- clk  in  1  block clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- cmd_req_i  in  1  new transfer request from reg_if.
- cmd_gnt_o  out  1  transfer accepted; comb.; high only in IDLE.
- cmd_size_i  in  TRANS_SIZE  transfer length in bytes.
- cmd_start_hi_i  in  1  first word taken from bits [63:32] of the first beat (byte address bit 2).
- in_data_i  in  64  beat from RDATA FIFO.
- in_valid_i  in  1  beat valid.
- in_ready_o  out  1  pop beat (comb.).
- out_data_o  out  32  word to uDMA RX channel (comb.).
- out_valid_o  out  1  word valid.
- out_ready_i  in  1  uDMA accepts word.
- out_datasize_o  out  2  constant 2'b10 (32-bit).
- out_last_o  out  1  current word is the final word of the transfer.
- eot_o  out  1  one-cycle end-of-transfer pulse (registered).
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset state and values:
  - state=IDLE, words_q=0, eot_o=0.
  - All comb. outputs resolve to 0 in IDLE, except cmd_gnt_o=cmd_req_i and out_datasize_o=2'b10.
- Word count: words = (cmd_size_i + 3) >> 2, computed in TRANS_SIZE+1 bits with no overflow.
  - words_q is TRANS_SIZE bits wide.
  - Trailing pad bytes of a non-multiple-of-4 size pass through unmodified.
- Latency: zero. out_data_o/out_valid_o are muxed combinationally from in_data_i/in_valid_i. There is no internal data storage.
- Word handshake is out_valid_o & out_ready_i. A beat pop is in_valid_i & in_ready_o.
- IDLE:
  - cmd_gnt_o = cmd_req_i.
  - On grant: words_q <= words.
  - If words==0: stay IDLE and pulse eot_o next cycle. No beat is consumed.
  - Otherwise go to HI if cmd_start_hi_i, else LO.
- LO:
  - out_data_o = in_data_i[31:0]; out_valid_o = in_valid_i.
  - in_ready_o = out_ready_i & (words_q==1). The last word pops its beat and discards the upper half.
  - On handshake: words_q--. If words_q==1 go to IDLE and set eot_o=1 next cycle; else go to HI.
- HI:
  - out_data_o = in_data_i[63:32]; out_valid_o = in_valid_i; in_ready_o = out_ready_i.
  - On handshake: words_q--. If words_q==1 go to IDLE and pulse eot; else go to LO.
- out_last_o = out_valid_o & (words_q==1).
- Control signals in IDLE:
  - in_ready_o=0, so beats arriving before a command stay in the FIFO.
  - cmd_req_i during a transfer is not granted (gnt=0). It is held by reg_if.
- Backpressure: with out_ready_i=0, no pop and no state change. Data is held by the upstream FIFO, and the valid/data pair stays stable.
- Counts beyond the supplied beats wait indefinitely on in_valid_i; there is no timeout.
- Asynchronous rst mid-transfer:
  - Returns immediately to IDLE with words_q=0 and no eot pulse.
  - A partially consumed beat is not popped. Upstream FIFO flush is the system's responsibility (shared reset).
- eot_o is asserted for exactly one cycle per granted command, including zero-size commands.

Decomposition:
- udma_mram_pkg holds:
  - state enum rx_unpack_state_e {IDLE, LO, HI}.
  - localparam UDMA_DSIZE_32 = 2'b10.
  - function words_from_bytes().
- No sub-module: single FSM plus counter. The TX counterpart (32→64 pack) reuses the package.

Test Plan:
- Size 16, start_lo, beats 64'h22222222_11111111, 64'h44444444_33333333 → words 11111111, 22222222, 33333333, 44444444. Two pops, both on the HI word. out_last on 44444444. One eot pulse.
- Size 10, start_lo → 3 words (11111111, 22222222, 33333333). Second beat popped on the third word; 44444444 never emitted. eot after third handshake.
- Size 8, start_hi, same beats → words 22222222, 33333333. First beat popped on the first word, second on the second. 11111111 and 44444444 are discarded.
- Size 0 → cmd_gnt_o same cycle, eot_o pulse next cycle, in_ready_o stays 0, FIFO untouched.
- Size 64 with random out_ready_i (50%) and random in_valid_i gaps → scoreboard matches 16 words in order. No duplicate or dropped word. Exactly 8 pops.
- rst pulsed after 3 words of a 32-byte transfer → busy_o=0 immediately and no eot. A following size-8 command completes normally.

Source files
------------

// File: rtl/udma_mram_pkg.sv
// rtl/udma_mram_pkg.sv - shared types, constants and helpers for the MRAM uDMA pack/unpack stages
package udma_mram_pkg;

  // Unpack FSM: IDLE waits for a command, LO/HI select which half of the current beat is emitted
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } rx_unpack_state_e;

  // uDMA datasize encoding for 32-bit words
  localparam logic [1:0] UDMA_DSIZE_32 = 2'b10;

  // Number of 32-bit words needed to cover a byte count (rounded up, no overflow)
  function automatic logic [31:0] words_from_bytes(input logic [31:0] bytes);
    logic [32:0] sum;
    sum = {1'b0, bytes} + 33'd3;
    return {1'b0, sum[32:2]};
  endfunction

endpackage

// File: rtl/rx_unpack_64_to_32.sv
// rtl/rx_unpack_64_to_32.sv - zero-latency unpacker from 64-bit RDATA beats to a 32-bit uDMA RX word stream
module rx_unpack_64_to_32
  import udma_mram_pkg::*;
#(
  parameter int TRANS_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_req_i,
  output logic                  cmd_gnt_o,
  input  logic [TRANS_SIZE-1:0] cmd_size_i,
  input  logic                  cmd_start_hi_i,
  input  logic [63:0]           in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [31:0]           out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [1:0]            out_datasize_o,
  output logic                  out_last_o,
  output logic                  eot_o,
  output logic                  busy_o
);

  rx_unpack_state_e      state_q, state_d;
  logic [TRANS_SIZE-1:0] words_q, words_d;
  logic                  eot_d;
  logic [31:0]           words_full;
  logic                  last_word;
  logic                  word_hs;

  // Word count is evaluated wide so a near-maximum byte size cannot wrap to zero
  assign words_full = words_from_bytes(32'(cmd_size_i));
  assign last_word  = (words_q == TRANS_SIZE'(1));
  assign word_hs    = out_valid_o & out_ready_i;

  assign out_datasize_o = UDMA_DSIZE_32;
  assign out_last_o     = out_valid_o & last_word;
  assign busy_o         = (state_q != IDLE);

  // State, remaining-word counter and registered end-of-transfer pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      words_q <= '0;
      eot_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      eot_o   <= eot_d;
    end
  end

  // Next-state and datapath mux; a beat is popped only when its last useful half is taken
  always_comb begin
    state_d     = state_q;
    words_d     = words_q;
    eot_d       = 1'b0;
    cmd_gnt_o   = 1'b0;
    in_ready_o  = 1'b0;
    out_data_o  = '0;
    out_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_gnt_o = cmd_req_i;
        if (cmd_req_i) begin
          words_d = words_full[TRANS_SIZE-1:0];
          if (words_full == 32'd0) begin
            eot_d = 1'b1;
          end else begin
            state_d = cmd_start_hi_i ? HI : LO;
          end
        end
      end
      LO: begin
        out_data_o  = in_data_i[31:0];
        out_valid_o = in_valid_i;
        // Upper half of the final beat is discarded, so the last word pops it here
        in_ready_o  = out_ready_i & last_word;
        if (word_hs) begin
          words_d = words_q - TRANS_SIZE'(1);
          if (last_word) begin
            state_d = IDLE;
            eot_d   = 1'b1;
          end else begin
            state_d = HI;
          end
        end
      end
      HI: begin
        out_data_o  = in_data_i[63:32];
        out_valid_o = in_valid_i;
        in_ready_o  = out_ready_i;
        if (word_hs) begin
          words_d = words_q - TRANS_SIZE'(1);
          if (last_word) begin
            state_d = IDLE;
            eot_d   = 1'b1;
          end else begin
            state_d = LO;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rx_unpack_64_to_32.sv
// tb/tb_rx_unpack_64_to_32.sv - self-checking bench for rx_unpack_64_to_32
module tb_rx_unpack_64_to_32;

  localparam int TS = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_req;
  logic          cmd_gnt;
  logic [TS-1:0] cmd_size;
  logic          cmd_start_hi;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_datasize;
  logic          out_last;
  logic          eot;
  logic          busy;

  always #5 clk = ~clk;

  rx_unpack_64_to_32 #(.TRANS_SIZE(TS)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_req_i      (cmd_req),
    .cmd_gnt_o      (cmd_gnt),
    .cmd_size_i     (cmd_size),
    .cmd_start_hi_i (cmd_start_hi),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .out_data_o     (out_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_datasize_o (out_datasize),
    .out_last_o     (out_last),
    .eot_o          (eot),
    .busy_o         (busy)
  );

  typedef struct {
    int size;
    bit hi;
    int nwords;
    int npops;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] beatq[$];
  logic [31:0] expq[$];
  logic [31:0] gotq[$];
  bit          lastq[$];
  int          pops;
  int          eot_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Beats consumed by a transfer: words are taken from the flattened lo/hi stream
  function automatic int model_pops(input int size, input bit hi);
    int n;
    n = (size + 3) / 4;
    return (n == 0) ? 0 : (n + int'(hi) + 1) / 2;
  endfunction

  task automatic load_beats(input int n, input bit rnd);
    logic [31:0] lo, hi;
    beatq.delete();
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        lo = $urandom;
        hi = $urandom;
      end else begin
        lo = 32'(2 * i + 1) * 32'h11111111;
        hi = 32'(2 * i + 2) * 32'h11111111;
      end
      beatq.push_back({hi, lo});
    end
  endtask

  task automatic start_cmd(input int size, input bit hi);
    int          n, idx;
    logic [63:0] w;
    n = (size + 3) / 4;
    expq.delete();
    for (int k = 0; k < n; k++) begin
      idx = k + int'(hi);
      w   = beatq[idx / 2];
      expq.push_back((idx % 2 == 1) ? w[63:32] : w[31:0]);
    end
    gotq.delete();
    lastq.delete();
    pops    = 0;
    eot_cnt = 0;
    @(negedge clk);
    cmd_req      = 1'b1;
    cmd_size     = TS'(size);
    cmd_start_hi = hi;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    #1;
    chk("cmd_gnt", 64'(cmd_gnt), 64'd1);
    chk("in_ready_idle", 64'(in_ready), 64'd0);
  endtask

  // mode 0: always ready/valid, 1: random gaps on both sides, 2: consumer stalled
  task automatic cycle(input int mode);
    @(negedge clk);
    cmd_req = 1'b0;
    if (beatq.size() > 0 && (mode != 1 || $urandom_range(1, 0) == 1)) begin
      in_valid = 1'b1;
      in_data  = beatq[0];
    end else begin
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
    end
    out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
    #1;
    if (eot) eot_cnt++;
    if (out_valid && out_ready) begin
      gotq.push_back(out_data);
      lastq.push_back(out_last);
    end
    if (in_valid && in_ready) begin
      void'(beatq.pop_front());
      pops++;
    end
  endtask

  task automatic finish_xfer(input string tag, input int n, input int np, input int mode);
    int c;
    c = 0;
    while (eot_cnt == 0 && c < 2000) begin
      cycle(mode);
      c++;
    end
    chk($sformatf("%s_timeout", tag), 64'(eot_cnt != 0), 64'd1);
    repeat (3) cycle(mode);
    chk($sformatf("%s_nwords", tag), 64'(gotq.size()), 64'(n));
    for (int i = 0; i < n && i < gotq.size(); i++) begin
      chk($sformatf("%s_word%0d", tag, i), 64'(gotq[i]), 64'(expq[i]));
      chk($sformatf("%s_last%0d", tag, i), 64'(lastq[i]), 64'(i == n - 1));
    end
    chk($sformatf("%s_pops", tag), 64'(pops), 64'(np));
    chk($sformatf("%s_eot_count", tag), 64'(eot_cnt), 64'd1);
    chk($sformatf("%s_busy_end", tag), 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    int   size, np, c;
    bit   hi;

    vt[0] = '{16, 1'b0, 4, 2};
    vt[1] = '{10, 1'b0, 3, 2};
    vt[2] = '{8,  1'b1, 2, 2};
    vt[3] = '{0,  1'b0, 0, 0};
    vt[4] = '{4,  1'b1, 1, 1};
    vt[5] = '{12, 1'b1, 3, 2};
    vt[6] = '{1,  1'b0, 1, 1};
    vt[7] = '{6,  1'b1, 2, 2};

    rst          = 1'b1;
    cmd_req      = 1'b0;
    cmd_size     = '0;
    cmd_start_hi = 1'b0;
    in_data      = 64'hdead_beef_cafe_f00d;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_eot", 64'(eot), 64'd0);
    chk("rst_gnt", 64'(cmd_gnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_datasize", 64'(out_datasize), 64'd2);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      load_beats(3, 1'b0);
      start_cmd(vt[i].size, vt[i].hi);
      finish_xfer($sformatf("vec%0d", i), vt[i].nwords, vt[i].npops, 0);
    end

    load_beats(3, 1'b0);
    start_cmd(8, 1'b0);
    repeat (4) cycle(2);
    chk("stall_pops", 64'(pops), 64'd0);
    chk("stall_words", 64'(gotq.size()), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    chk("stall_out_data", 64'(out_data), 64'h11111111);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    finish_xfer("stall", 2, 1, 0);

    for (int r = 0; r < 6; r++) begin
      size = (r == 0) ? 64 : int'($urandom_range(40, 1));
      hi   = (r == 0) ? 1'b0 : 1'($urandom_range(1, 0));
      np   = model_pops(size, hi);
      load_beats(np + 1, 1'b1);
      start_cmd(size, hi);
      finish_xfer($sformatf("rand%0d", r), (size + 3) / 4, np, 1);
    end

    load_beats(4, 1'b0);
    start_cmd(32, 1'b0);
    c = 0;
    while (gotq.size() < 3 && c < 100) begin
      cycle(0);
      c++;
    end
    cmd_req = 1'b1;
    #1;
    chk("busy_gnt", 64'(cmd_gnt), 64'd0);
    cmd_req = 1'b0;
    rst     = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_words", 64'(gotq.size()), 64'd3);
    @(negedge clk);
    rst = 1'b0;
    beatq.delete();
    eot_cnt = 0;
    repeat (3) cycle(0);
    chk("midrst_no_eot", 64'(eot_cnt), 64'd0);
    load_beats(2, 1'b0);
    start_cmd(8, 1'b1);
    finish_xfer("post_rst", 2, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
